// File: rtl/serial_word_shifter_if.sv
// rtl/serial_word_shifter_if.sv - word-in / bit-out bundle for serial_word_shifter
//   din/din_valid/din_ready : parallel word handshake (master drives din, din_valid)
//   x/x_valid               : serial bit stream, LSB first
//   sof/eof                 : first / last bit of each word
//   busy                    : shifter is serializing or in its idle gap
interface serial_word_shifter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, sof, eof, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, sof, eof, busy
  );
endinterface

// File: rtl/serial_word_shifter.sv
// rtl/serial_word_shifter.sv - parallel word to LSB-first serial stream with sof/eof markers
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serial_word_shifter_if slave (din/din_valid in, din_ready/x/x_valid/sof/eof/busy out)
//   WIDTH   : word length, 2..32
//   GAP     : idle cycles after each word, 0..15
module serial_word_shifter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  serial_word_shifter_if.slave   bus
);

  localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LD = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gap;

  logic w_last;
  logic w_ready;
  logic w_hs;
  logic w_load;
  logic w_shift;
  logic w_gap_ld;
  logic w_in_shift;

  assign w_last = (r_cnt == LAST);

  // Ready is gated by reset so it drops the instant reset asserts, even though
  // the state register already sits in IDLE. In SHIFT, ready is only offered on
  // the last bit when no gap follows, which gives back-to-back words.
  assign w_ready = i_rst_n &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_SHIFT) && w_last && (GAP == 0)));

  assign w_hs = bus.din_valid & w_ready;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_gap_ld = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          if (GAP != 0) begin
            w_next   = S_GAP;
            w_gap_ld = 1'b1;
          end else if (w_hs) begin
            w_load = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap <= 4'd1) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      // A reload takes priority over the shift on the last bit of a word.
      if (w_load) begin
        r_sr  <= bus.din;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sr  <= {1'b0, r_sr[WIDTH-1:1]};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_gap_ld) begin
        r_gap <= GAP_LD;
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign w_in_shift    = (r_state == S_SHIFT);
  assign bus.din_ready = w_ready;
  assign bus.x         = w_in_shift & r_sr[0];
  assign bus.x_valid   = w_in_shift;
  assign bus.sof       = w_in_shift & (r_cnt == '0);
  assign bus.eof       = w_in_shift & w_last;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_word_shifter.sv
// tb/tb_serial_word_shifter.sv - directed self-checking bench for serial_word_shifter
module tb_serial_word_shifter;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [15:0] seq;
  logic [7:0]  zw;
  logic        r_seen;
  logic        z;

  serial_word_shifter_if #(.WIDTH(8)) b8 ();
  serial_word_shifter_if #(.WIDTH(8)) b0 ();
  serial_word_shifter_if #(.WIDTH(2)) b2 ();

  serial_word_shifter #(.WIDTH(8), .GAP(1)) u_w8_g1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
  serial_word_shifter #(.WIDTH(8), .GAP(0)) u_w8_g0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  serial_word_shifter #(.WIDTH(2), .GAP(0)) u_w2_g0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream serial two's-complement stage: copy bits up to and including
  // the first 1, invert every bit after it; restarts on sof.
  assign z = b8.x ^ (b8.sof ? 1'b0 : r_seen);
  always @(posedge clk) begin
    if (b8.x_valid) begin
      r_seen <= (b8.sof ? 1'b0 : r_seen) | b8.x;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    r_seen   = 1'b0;
    rst_n    = 1'b0;
    b8.din = '0; b8.din_valid = 1'b0;
    b0.din = '0; b0.din_valid = 1'b0;
    b2.din = '0; b2.din_valid = 1'b0;

    // Reset state
    tick();
    chk("reset_outs_w8g1", {b8.x, b8.x_valid, b8.sof, b8.eof, b8.busy, b8.din_ready}, 6'b0);
    chk("reset_outs_w8g0", {b0.x, b0.x_valid, b0.sof, b0.eof, b0.busy, b0.din_ready}, 6'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {b8.busy, b8.din_ready}, 2'b01);

    // Word 0x6D, GAP=1: stream 1,0,1,1,0,1,1,0
    b8.din = 8'h6D; b8.din_valid = 1'b1;
    tick();
    b8.din_valid = 1'b0; b8.din = 8'h00;
    seq = 16'h006D;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("w6d_bit%0d", k), {b8.x, b8.x_valid, b8.sof, b8.eof, b8.din_ready},
          {seq[k], 1'b1, k == 0, k == 7, 1'b0});
      tick();
    end
    chk("w6d_gap", {b8.x_valid, b8.busy, b8.din_ready}, 3'b010);
    tick();
    chk("w6d_idle", {b8.x_valid, b8.busy, b8.din_ready}, 3'b001);

    // GAP=0 back-to-back 0xA5 then 0x3C: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0
    b0.din = 8'hA5; b0.din_valid = 1'b1;
    tick();
    b0.din = 8'h3C;
    seq = 16'h3CA5;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b2b_bit%0d", k), {b0.x, b0.x_valid, b0.sof, b0.eof, b0.din_ready},
          {seq[k], 1'b1, (k == 0) || (k == 8), (k == 7) || (k == 15), (k == 7) || (k == 15)});
      if (k == 8) b0.din_valid = 1'b0;
      tick();
    end
    chk("b2b_idle", {b0.x_valid, b0.busy}, 2'b00);

    // din changes 0x11 -> 0xFF while busy; only 0x11 serialized first
    b8.din = 8'h11; b8.din_valid = 1'b1;
    tick();
    b8.din = 8'hFF;
    seq = 16'h0011;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold_bit%0d", k), {b8.x, b8.x_valid, b8.sof, b8.eof, b8.din_ready},
          {seq[k], 1'b1, k == 0, k == 7, 1'b0});
      tick();
    end
    chk("hold_gap", {b8.x_valid, b8.din_ready}, 2'b00);
    tick();
    chk("hold_idle_ready", b8.din_ready, 1'b1);
    tick();

    // 0xFF now shifting; assert reset during bit 3
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ff_bit%0d", k), {b8.x, b8.x_valid, b8.sof}, {1'b1, 1'b1, k == 0});
      if (k < 3) tick();
    end
    b8.din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", {b8.x, b8.x_valid, b8.sof, b8.eof, b8.busy, b8.din_ready}, 6'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_release", {b8.x_valid, b8.busy, b8.din_ready}, 3'b001);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_quiet%0d", k), {b8.x_valid, b8.busy}, 2'b00);
    end

    // WIDTH=2: 2'b10 then 2'b11 -> 0,1,1,1
    b2.din = 2'b10; b2.din_valid = 1'b1;
    tick();
    b2.din = 2'b11;
    seq = 16'h000E;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w2_bit%0d", k), {b2.x, b2.x_valid, b2.sof, b2.eof},
          {seq[k], 1'b1, (k == 0) || (k == 2), (k == 1) || (k == 3)});
      if (k == 2) b2.din_valid = 1'b0;
      tick();
    end
    chk("w2_idle", {b2.x_valid, b2.din_ready}, 2'b01);

    // All-zero word still produces 8 valid bits
    b8.din = 8'h00; b8.din_valid = 1'b1;
    tick();
    b8.din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("zero_bit%0d", k), {b8.x, b8.x_valid}, 2'b01);
      tick();
    end
    tick();
    chk("zero_idle", b8.din_ready, 1'b1);

    // Cascade into two's-complement stage: 0x06 -> 0xFA
    b8.din = 8'h06; b8.din_valid = 1'b1;
    tick();
    b8.din_valid = 1'b0;
    zw = 8'h00;
    for (int k = 0; k < 8; k++) begin
      zw[k] = z;
      tick();
    end
    chk("cascade_z", zw, 8'hFA);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
